// File: rtl/shrike_pkg.sv
// rtl/shrike_pkg.sv - shared states, select encodings, opcodes and trap causes for the Shrike-V sequencer
package shrike_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_IMM  = 2'd1;
  localparam logic [1:0] PC_SEL_ALU  = 2'd2;
  localparam logic [1:0] PC_SEL_TRAP = 2'd3;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMMU = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OPIMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NOP,
    CLS_ILLEGAL
  } instr_cls_e;

  // Sorts an instruction into the sequencing class that decides its path after EXEC.
  function automatic instr_cls_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
    instr_cls_e cls;
    case (opcode)
      OPC_OP:       cls = CLS_OP;
      OPC_OP_IMM:   cls = CLS_OPIMM;
      OPC_LUI:      cls = CLS_LUI;
      OPC_AUIPC:    cls = CLS_AUIPC;
      OPC_JAL:      cls = CLS_JAL;
      OPC_JALR:     cls = CLS_JALR;
      OPC_LOAD:     cls = (funct3 == 3'd3 || funct3 >= 3'd6) ? CLS_ILLEGAL : CLS_LOAD;
      OPC_STORE:    cls = (funct3 >= 3'd3) ? CLS_ILLEGAL : CLS_STORE;
      OPC_BRANCH:   cls = (funct3 == 3'd2 || funct3 == 3'd3) ? CLS_ILLEGAL : CLS_BRANCH;
      OPC_MISC_MEM: cls = CLS_NOP;
      OPC_SYSTEM:   cls = CLS_NOP;
      default:      cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/riscv_mem_watchdog.sv
// rtl/riscv_mem_watchdog.sv - saturating wait counter that flags a stuck memory transfer
module riscv_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Expiry is flagged in the wait cycle that brings the count up to the limit,
  // so exactly MEM_TIMEOUT request cycles elapse before the sequencer traps.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over count; the count sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && count_i && (cnt_q == LAST);

endmodule

// File: rtl/riscv_control_fsm.sv
// rtl/riscv_control_fsm.sv - multi-cycle RV32I control sequencer; SHRIKE_ILLEGAL_TRAP_EN traps illegal encodings
module riscv_control_fsm
  import shrike_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [2:0] imm_sel,
  output logic       retire,
  output logic       trap,
  output logic [3:0] trap_cause
);

  state_e     state_q, state_d;
  logic [3:0] trap_cause_q, trap_cause_d;
  instr_cls_e cls_raw, cls;
  logic       op_alu_a, op_alu_b;
  logic [2:0] op_imm;
  logic       wd_clear, wd_count, wd_expired;

  assign cls_raw = classify(opcode, funct3);

  // Illegal encodings either trap or degrade to a retiring NOP.
  always_comb begin
`ifdef SHRIKE_ILLEGAL_TRAP_EN
    cls = cls_raw;
`else
    cls = (cls_raw == CLS_ILLEGAL) ? CLS_NOP : cls_raw;
`endif
  end

  // Operand and immediate selects depend only on the opcode in the IR.
  always_comb begin
    op_alu_a = 1'b0;
    op_alu_b = 1'b0;
    op_imm   = IMM_I;
    case (opcode)
      OPC_AUIPC: begin
        op_alu_a = 1'b1;
        op_imm   = IMM_U;
      end
      OPC_JAL: begin
        op_alu_a = 1'b1;
        op_imm   = IMM_J;
      end
      OPC_BRANCH: begin
        op_alu_a = 1'b1;
        op_imm   = IMM_B;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        op_alu_b = 1'b1;
      end
      OPC_STORE: begin
        op_alu_b = 1'b1;
        op_imm   = IMM_S;
      end
      OPC_LUI: begin
        op_imm = IMM_U;
      end
      default: begin
      end
    endcase
  end

  // Wait cycles are counted only in the two states that own the memory port.
  assign wd_count = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign wd_clear = (state_d != state_q);

  riscv_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (wd_clear),
    .count_i  (wd_count),
    .expired_o(wd_expired)
  );

  // Next-state and datapath strobes; every output defaults low.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_sel      = IMM_I;
    retire       = 1'b0;
    trap         = 1'b0;

    if (state_q == ST_DECODE || state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_a_sel = op_alu_a;
      alu_b_sel = op_alu_b;
      imm_sel   = op_imm;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_FETCH_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = ST_MEM;
          end
          CLS_ILLEGAL: begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
          default: begin
            state_d = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wd_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = (cls == CLS_STORE) ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
        end
      end
      ST_WB: begin
        rf_we = !(cls == CLS_NOP || cls == CLS_ILLEGAL);
        case (cls)
          CLS_LOAD:          wb_sel = WB_SEL_LOAD;
          CLS_JAL, CLS_JALR: wb_sel = WB_SEL_PC4;
          CLS_LUI:           wb_sel = WB_SEL_IMMU;
          default:           wb_sel = WB_SEL_ALU;
        endcase
        pc_we = 1'b1;
        case (cls)
          CLS_JAL:  pc_sel = PC_SEL_IMM;
          CLS_JALR: pc_sel = PC_SEL_ALU;
          default:  pc_sel = PC_SEL_PC4;
        endcase
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_SEL_TRAP;
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and sticky trap cause; reset drops straight back to BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb/tb_riscv_control_fsm.sv - randomized instruction-level check of riscv_control_fsm
module tb_riscv_control_fsm;

  localparam int TMO = 4;

`ifdef SHRIKE_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP = 1'b1;
`else
  localparam bit ILL_TRAP = 1'b0;
`endif

  localparam int K_OP = 0, K_OPIMM = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5;
  localparam int K_LOAD = 6, K_STORE = 7, K_BR = 8, K_NOP = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic [1:0] pc_sel, wb_sel;
  logic       alu_a_sel, alu_b_sel, retire, trap;
  logic [2:0] imm_sel;
  logic [3:0] trap_cause;

  riscv_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] imm_sel;
    logic       retire;
    logic       trap;
    logic [3:0] trap_cause;
  } outv_t;

  outv_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ret_cyc = -1;
  int         req_cycles = 0;
  logic [3:0] trap_cause_seen = '0;
  logic [3:0] cause_hold = '0;

  function automatic outv_t dut_vec();
    outv_t v;
    v.mem_req = mem_req;     v.mem_we = mem_we;       v.mem_addr_sel = mem_addr_sel;
    v.ir_we = ir_we;         v.pc_we = pc_we;         v.pc_sel = pc_sel;
    v.rf_we = rf_we;         v.wb_sel = wb_sel;       v.alu_a_sel = alu_a_sel;
    v.alu_b_sel = alu_b_sel; v.imm_sel = imm_sel;     v.retire = retire;
    v.trap = trap;           v.trap_cause = trap_cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every cycle with a pushed expectation is checked at the falling edge.
  always @(negedge clk) begin
    outv_t a;
    outv_t e;
    a = dut_vec();
    if (a.mem_req) req_cycles++;
    if (a.retire) ret_cyc = cyc;
    if (a.trap) trap_cause_seen = a.trap_cause;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'(a), 32'(e));
    end
  end

  // Class of an instruction from the legal-funct3 masks of RV32I.
  function automatic int kind(input logic [6:0] opc, input logic [2:0] f3);
    logic [7:0] ok;
    int k;
    ok = 8'hFF;
    case (opc)
      7'h33: k = K_OP;
      7'h13: k = K_OPIMM;
      7'h37: k = K_LUI;
      7'h17: k = K_AUIPC;
      7'h6F: k = K_JAL;
      7'h67: k = K_JALR;
      7'h03: begin k = K_LOAD;  ok = 8'b0011_0111; end
      7'h23: begin k = K_STORE; ok = 8'b0000_0111; end
      7'h63: begin k = K_BR;    ok = 8'b1111_0011; end
      7'h0F, 7'h73: k = K_NOP;
      default: k = K_ILL;
    endcase
    if (!ok[f3]) k = K_ILL;
    return k;
  endfunction

  // Selects visible once the IR holds the instruction.
  function automatic outv_t post_fetch(input logic [6:0] opc);
    outv_t v;
    v = '0;
    v.trap_cause = cause_hold;
    case (opc)
      7'h17: begin v.alu_a_sel = 1'b1; v.imm_sel = 3'd3; end
      7'h6F: begin v.alu_a_sel = 1'b1; v.imm_sel = 3'd4; end
      7'h63: begin v.alu_a_sel = 1'b1; v.imm_sel = 3'd2; end
      7'h13, 7'h03, 7'h67: v.alu_b_sel = 1'b1;
      7'h23: begin v.alu_b_sel = 1'b1; v.imm_sel = 3'd1; end
      7'h37: v.imm_sel = 3'd3;
      default: ;
    endcase
    return v;
  endfunction

  task automatic step(input logic rdy, input outv_t e);
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic trap_step(input logic [3:0] c);
    outv_t e;
    cause_hold = c;
    e = '0;
    e.trap = 1'b1;
    e.pc_we = 1'b1;
    e.pc_sel = 2'd3;
    e.trap_cause = c;
    step(1'($urandom), e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reset outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    cause_hold = '0;
    step(1'($urandom), outv_t'(0));
  endtask

  task automatic instr_body(input logic [6:0] opc, input logic [2:0] f3, input logic bt,
                            input int fw, input int mw, input bit rst_mid);
    outv_t e;
    int k;
    for (int i = 0; i <= fw; i++) begin
      opcode = 7'($urandom);
      funct3 = 3'($urandom);
      branch_taken = 1'($urandom);
      e = '0;
      e.mem_req = 1'b1;
      e.trap_cause = cause_hold;
      if (i == fw) begin
        e.ir_we = 1'b1;
        step(1'b1, e);
      end else if (i == TMO - 1) begin
        step(1'b0, e);
        trap_step(4'd1);
        return;
      end else begin
        step(1'b0, e);
      end
    end
    opcode = opc;
    funct3 = f3;
    k = kind(opc, f3);
    step(1'($urandom), post_fetch(opc));
    branch_taken = bt;
    e = post_fetch(opc);
    if (k == K_BR) begin
      e.pc_we = 1'b1;
      e.pc_sel = {1'b0, bt};
      e.retire = 1'b1;
      step(1'($urandom), e);
      return;
    end
    step(1'($urandom), e);
    if (k == K_ILL && ILL_TRAP) begin
      trap_step(4'd2);
      return;
    end
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        e = post_fetch(opc);
        e.mem_req = 1'b1;
        e.mem_addr_sel = 1'b1;
        e.mem_we = (k == K_STORE);
        if (rst_mid && i == 1) begin
          rst_n = 1'b0;
          #1;
          check("async reset mem_req", 32'(mem_req), 32'd0);
          check("async reset outputs", 32'(dut_vec()), 32'd0);
          return;
        end
        if (i == mw) begin
          if (k == K_STORE) begin
            e.pc_we = 1'b1;
            e.retire = 1'b1;
            step(1'b1, e);
            return;
          end
          step(1'b1, e);
        end else if (i == TMO - 1) begin
          step(1'b0, e);
          trap_step((k == K_STORE) ? 4'd7 : 4'd5);
          return;
        end else begin
          step(1'b0, e);
        end
      end
    end
    e = post_fetch(opc);
    e.rf_we = !(k == K_NOP || k == K_ILL);
    case (k)
      K_LOAD:         e.wb_sel = 2'd1;
      K_JAL, K_JALR:  e.wb_sel = 2'd2;
      K_LUI:          e.wb_sel = 2'd3;
      default:        e.wb_sel = 2'd0;
    endcase
    e.pc_we = 1'b1;
    e.pc_sel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    e.retire = 1'b1;
    step(1'($urandom), e);
  endtask

  // Latency is measured from the DUT's own retire pulse; -1 when nothing retired.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic bt,
                           input int fw, input int mw, input bit rst_mid, output int lat);
    int start;
    start = cyc;
    instr_body(opc, f3, bt, fw, mw, rst_mid);
    lat = (ret_cyc >= start) ? (ret_cyc - start + 1) : -1;
  endtask

  logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                              7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};

  initial begin
    int lat;
    logic [6:0] opc;
    int fw, mw;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(7'h13, 3'd0, 1'b0, 0, 0, 1'b0, lat);
    check("addi latency", 32'(lat), 32'd4);

    req_cycles = 0;
    run_instr(7'h03, 3'd2, 1'b0, 0, 3, 1'b0, lat);
    check("lw latency", 32'(lat), 32'd8);
    check("lw req cycles", 32'(req_cycles), 32'd5);

    run_instr(7'h63, 3'd0, 1'b1, 0, 0, 1'b0, lat);
    check("beq taken latency", 32'(lat), 32'd3);
    run_instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b0, lat);
    check("beq not-taken latency", 32'(lat), 32'd3);

    run_instr(7'h67, 3'd0, 1'b0, 0, 0, 1'b0, lat);
    check("jalr latency", 32'(lat), 32'd4);

    req_cycles = 0;
    trap_cause_seen = '0;
    run_instr(7'h13, 3'd0, 1'b0, TMO + 2, 0, 1'b0, lat);
    check("fetch timeout req cycles", 32'(req_cycles), 32'd4);
    check("fetch timeout cause", 32'(trap_cause_seen), 32'd1);

    run_instr(7'h33, 3'd0, 1'b0, 0, 0, 1'b0, lat);
    check("after trap latency", 32'(lat), 32'd4);

    run_instr(7'h23, 3'd2, 1'b0, 0, 5, 1'b1, lat);
    do_reset();

    trap_cause_seen = '0;
    run_instr(7'h7F, 3'd0, 1'b0, 0, 0, 1'b0, lat);
`ifdef SHRIKE_ILLEGAL_TRAP_EN
    check("illegal trap cause", 32'(trap_cause_seen), 32'd2);
`else
    check("illegal nop latency", 32'(lat), 32'd4);
`endif

    repeat (300) begin
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
      else opc = opc_tab[$urandom_range(0, 10)];
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO + 1)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TMO + 1)) : 0;
      run_instr(opc, 3'($urandom), 1'($urandom), fw, mw, 1'b0, lat);
    end

    check("expectations drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/riscv_control_fsm.md
# riscv_control_fsm

Multi-cycle control sequencer for the Shrike-V RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath strobe and mux select. It consumes the opcode and funct3 fields from the instruction decoder plus the branch comparator result, and owns the single memory port handshake, including a watchdog timeout. It sits between the instruction register/decoder and the PC, register-file, ALU and memory-port muxes.

## Interface
- MEM_TIMEOUT, 255: max cycles `mem_req` may wait for `mem_ready`; 0 disables the watchdog.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  from decoder, `instr[6:0]` of the current IR
- funct3  in  3  from decoder
- branch_taken  in  1  branch comparator result, valid in EXEC
- mem_ready  in  1  memory completes the transfer this cycle
- mem_req  out  1  memory request
- mem_we  out  1  store when high
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = (ALU & ~1), 3 = trap vector
- rf_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm_u
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
- retire  out  1  one-cycle pulse when the instruction commits (PC write)
- trap  out  1  one-cycle pulse in TRAP
- trap_cause  out  4  RISC-V mcause code; held until the next trap

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset forces BOOT.
- In BOOT, and while reset is asserted, all outputs are 0 (`trap_cause` is 0). BOOT goes to FETCH after one cycle.
- FETCH
  - Drives `mem_req`=1, `mem_addr_sel`=0.
  - When `mem_ready` is high: `ir_we`=1, then DECODE.
- DECODE: one cycle for the register-file read. `imm_sel` is driven from the opcode. Goes to EXEC.
- EXEC, by opcode:
  - OP / OP-IMM / LUI / AUIPC / JAL / JALR: go to WB.
  - LOAD / STORE: go to MEM.
  - BRANCH: `pc_we`=1, `pc_sel`=`branch_taken`?1:0, `retire`=1, then FETCH.
  - FENCE / SYSTEM: go to WB with no register write (NOP).
- ALU operand selects:
  - AUIPC, JAL and BRANCH targets use `alu_a_sel`=1.
  - OP-IMM, LOAD, STORE and JALR use `alu_b_sel`=1.
- MEM
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(STORE).
  - On `mem_ready`: a load goes to WB; a store does `pc_we`=1, `pc_sel`=0, `retire`=1, then FETCH.
- WB
  - `rf_we`=1, except FENCE / SYSTEM / NOP.
  - `wb_sel`: ALU for OP/OP-IMM/AUIPC, 1 for LOAD, 2 for JAL/JALR, 3 for LUI.
  - `pc_we`=1 with `pc_sel`: 1 for JAL, 2 for JALR, otherwise 0.
  - `retire`=1, then FETCH.
- Watchdog
  - Counter is cleared on entry to FETCH or MEM.
  - It increments each cycle `mem_req` is high and `mem_ready` is low.
  - On reaching MEM_TIMEOUT: go to TRAP with cause 1 (fetch), 5 (load) or 7 (store).
- TRAP: `trap`=1, `pc_we`=1, `pc_sel`=3, `mem_req`=0, `rf_we`=0; then FETCH. No `retire`.
- Outputs are combinational from state, opcode, funct3, `branch_taken` and `mem_ready`. The state register and watchdog counter are the only flops, besides `trap_cause`.

## Timing
- `mem_ready` may be high in the first cycle `mem_req` is high, giving a zero-wait transfer.
- `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready` is sampled high. `mem_req` deasserts the following cycle.
- Zero-wait latency, FETCH to `retire` inclusive:
  - branch: 3 cycles
  - store: 4 cycles
  - ALU / LUI / AUIPC / JAL / JALR / NOP: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds one.
- `mem_ready` high outside FETCH/MEM is ignored.
- If `mem_ready` and the watchdog limit occur in the same cycle, `mem_ready` wins.
- Watchdog counter width is $clog2(MEM_TIMEOUT+1). It saturates and cannot wrap.
- Reset asserted mid-operation: state goes to BOOT immediately and `mem_req` drops asynchronously. The in-flight transfer is abandoned and the counter is cleared.

## Configuration
- `SHRIKE_ILLEGAL_TRAP_EN` defined:
  - Unknown opcodes, LOAD funct3 ∈ {3,6,7}, STORE funct3 ≥ 3 and BRANCH funct3 ∈ {2,3} go EXEC → TRAP with cause 2.
- Undefined: these are NOPs (EXEC → WB, `rf_we`=0, PC+4, `retire`=1).

## Structure
- `shrike_pkg` holds:
  - state enum
  - `pc_sel`, `wb_sel` and `imm_sel` encodings
  - RV32I opcode constants
  - trap cause constants
- Sub-module `riscv_mem_watchdog`: the timeout counter, with clear/count/expired ports, parameterised by MEM_TIMEOUT.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait → FETCH/DECODE/EXEC/WB. WB shows `rf_we`=1, `wb_sel`=0, `alu_b_sel`=1, `pc_sel`=0. `retire` in cycle 4.
- LW (0x0000A103) with `mem_ready` 3 cycles late in MEM → `mem_req` high 4 cycles with `mem_addr_sel`=1, `mem_we`=0. Then WB with `wb_sel`=1. `retire` in cycle 8.
- BEQ (0x00208463):
  - `branch_taken`=1 → `pc_sel`=1 in EXEC, no `rf_we`, `retire` in cycle 3.
  - `branch_taken`=0 → `pc_sel`=0.
- JALR (0x000080E7) → WB shows `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=2.
- MEM_TIMEOUT=4, fetch with `mem_ready` held low → 4 request cycles, then `trap`=1, `trap_cause`=1, `pc_sel`=3, then FETCH. Async reset asserted during a store MEM → `mem_req`=0 immediately, BOOT.
- Opcode 0x7F (instr 0x0000007F):
  - macro defined → `trap`, `trap_cause`=2, no `rf_we`.
  - macro undefined → `retire` with `pc_sel`=0, `rf_we`=0.
